// File: rtl/instr_stream_encoder_if.sv
// Request and IMEM-write bundle for instr_stream_encoder.
// master: boot loader / testbench side; slave: the encoder itself.
interface instr_stream_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [25:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err_illegal;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_wdata, count, full, err_illegal
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// instr_stream_encoder: turns symbolic MIPS instruction requests into 32-bit
// words and writes them to consecutive IMEM addresses, one word every two cycles.
// Stops (FULL) after DEPTH words; clear rewinds to BASE_ADDR.
module instr_stream_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  instr_stream_encoder_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [ADDR_W-1:0] BASE_PTR  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  // Returns {legal, word}; fields not used by the format are never copied in.
  function automatic logic [32:0] encode(
    input logic [4:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [32:0] res;
    res = 33'd0;
    case (op)
      5'd0:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h20};
      5'd1:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h21};
      5'd2:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h22};
      5'd3:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h23};
      5'd4:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h24};
      5'd5:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h25};
      5'd6:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h27};
      5'd7:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h26};
      5'd8:  res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h2a};
      5'd9:  res = {1'b1, 6'h00, 5'd0, rt, rd, shamt, 6'h00};
      5'd10: res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h04};
      5'd11: res = {1'b1, 6'h00, 5'd0, rt, rd, shamt, 6'h02};
      5'd12: res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h06};
      5'd13: res = {1'b1, 6'h00, 5'd0, rt, rd, shamt, 6'h03};
      5'd14: res = {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h07};
      5'd15: res = {1'b1, 6'h00, rs, 15'd0, 6'h08};
      5'd16: res = {1'b1, 6'h04, rs, rt, imm};
      5'd17: res = {1'b1, 6'h05, rs, rt, imm};
      5'd18: res = {1'b1, 6'h23, rs, rt, imm};
      5'd19: res = {1'b1, 6'h2b, rs, rt, imm};
      5'd20: res = {1'b1, 6'h08, rs, rt, imm};
      5'd21: res = {1'b1, 6'h09, rs, rt, imm};
      5'd22: res = {1'b1, 6'h0c, rs, rt, imm};
      5'd23: res = {1'b1, 6'h0d, rs, rt, imm};
      5'd24: res = {1'b1, 6'h0e, rs, rt, imm};
      5'd25: res = {1'b1, 6'h02, target};
      5'd26: res = {1'b1, 6'h03, target};
      default: res = 33'd0;
    endcase
    return res;
  endfunction

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_count;
  logic [31:0]       r_word;
  logic              r_err;

  logic [32:0]       w_enc;
  logic              w_accept;
  logic              w_we;

  assign w_enc    = encode(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                           bus.in_shamt, bus.in_imm, bus.in_target);
  assign w_accept = bus.in_valid && bus.in_ready;
  // clear kills a write in the very cycle it is asserted, so the strobe is gated here.
  assign w_we     = (r_state == S_WRITE) && !clear;

  assign bus.in_ready    = (r_state == S_IDLE) && !clear;
  assign bus.imem_we     = w_we;
  assign bus.imem_addr   = r_ptr;
  assign bus.imem_wdata  = w_we ? r_word : 32'd0;
  assign bus.count       = r_count;
  assign bus.full        = (r_state == S_FULL);
  assign bus.err_illegal = r_err;

  // Sequencer: accept/encode in IDLE, commit the word in WRITE, park in FULL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= BASE_PTR;
      r_count <= '0;
      r_word  <= 32'd0;
      r_err   <= 1'b0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_ptr   <= BASE_PTR;
      r_count <= '0;
      r_word  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_enc[32]) begin
              r_word  <= w_enc[31:0];
              r_state <= S_WRITE;
            end else begin
              r_err   <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_count <= r_count + (ADDR_W+1)'(1);
          r_state <= ((r_count + (ADDR_W+1)'(1)) == DEPTH_CNT) ? S_FULL : S_IDLE;
        end
        S_FULL: r_state <= S_FULL;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder (DEPTH=4 so FULL is reached often).
// A transaction-level model predicts every output each cycle.
module tb_instr_stream_encoder;

  localparam int ADDR_W = 8;
  localparam int BASE   = 0;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;
  logic clear;

  instr_stream_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_stream_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Format kind per op: 0 R-ALU, 1 shift-imm, 2 jr, 3 I-type, 4 J-type.
  int unsigned kind_t [27] = '{0,0,0,0,0,0,0,0,0,1,0,1,0,1,0,2,3,3,3,3,3,3,3,3,3,4,4};
  int unsigned code_t [27] = '{32'h20,32'h21,32'h22,32'h23,32'h24,32'h25,32'h27,32'h26,
                               32'h2a,32'h00,32'h04,32'h02,32'h06,32'h03,32'h07,32'h08,
                               32'h04,32'h05,32'h23,32'h2b,32'h08,32'h09,32'h0c,32'h0d,
                               32'h0e,32'h02,32'h03};

  // Model state: a word waiting for its write cycle, words written, error pulse.
  bit          m_busy;
  logic [31:0] m_word;
  int          m_count;
  bit          m_err;

  function automatic logic [31:0] ref_word(input int unsigned op, rs, rt, rd, sh, imm, tgt);
    int unsigned w;
    case (kind_t[op])
      0: w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + code_t[op];
      1: w = rt * (1 << 16) + rd * (1 << 11) + sh * (1 << 6) + code_t[op];
      2: w = rs * (1 << 21) + 32'h08;
      3: w = code_t[op] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
      default: w = code_t[op] * (1 << 26) + tgt;
    endcase
    return w;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit exp_we;
    exp_we = m_busy && !clear;
    check_val("we",    32'(bus.imem_we), 32'(exp_we));
    check_val("addr",  32'(bus.imem_addr), 32'(BASE + m_count));
    check_val("wdata", bus.imem_wdata, exp_we ? m_word : 32'd0);
    check_val("count", 32'(bus.count), 32'(m_count));
    check_val("full",  32'(bus.full), 32'(m_count == DEPTH));
    check_val("err",   32'(bus.err_illegal), 32'(m_err));
    check_val("ready", 32'(bus.in_ready), 32'(!m_busy && m_count != DEPTH && !clear));
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_word  = 32'd0;
    m_count = 0;
    m_err   = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    if (clear) begin
      model_reset();
    end else if (m_busy) begin
      m_count++;
      m_busy = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_count < DEPTH && bus.in_valid) begin
        if (bus.in_op < 5'd27) begin
          m_busy = 1'b1;
          m_word = ref_word(bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                            bus.in_shamt, bus.in_imm, bus.in_target);
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic set_req(input bit v, input int unsigned op, rs, rt, rd, sh, imm, tgt);
    bus.in_valid  = v;
    bus.in_op     = 5'(op);
    bus.in_rs     = 5'(rs);
    bus.in_rt     = 5'(rt);
    bus.in_rd     = 5'(rd);
    bus.in_shamt  = 5'(sh);
    bus.in_imm    = 16'(imm);
    bus.in_target = 26'(tgt);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    set_req(1'b0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_all();

    // add -> first word at BASE
    set_req(1'b1, 0, 1, 2, 3, 9, 16'hffff, 26'h3ffffff);
    tick();
    check_val("add_word", bus.imem_wdata, 32'h00221820);
    check_val("add_we", 32'(bus.imem_we), 32'd1);
    set_req(1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_val("add_count", 32'(bus.count), 32'd1);

    // sll with rs set: rs must not leak
    set_req(1'b1, 9, 7, 4, 5, 2, 16'h1234, 26'h1);
    tick();
    check_val("sll_word", bus.imem_wdata, 32'h00042880);
    set_req(1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // illegal op: pulse, no write, count unchanged
    set_req(1'b1, 31, 1, 1, 1, 1, 1, 1);
    tick();
    check_val("ill_err", 32'(bus.err_illegal), 32'd1);
    check_val("ill_we", 32'(bus.imem_we), 32'd0);
    set_req(1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_val("ill_count", 32'(bus.count), 32'd2);

    // lw lands at the address the illegal op did not consume
    set_req(1'b1, 18, 29, 8, 31, 31, 4, 26'h2aaaaaa);
    tick();
    check_val("lw_word", bus.imem_wdata, 32'h8FA80004);
    check_val("lw_addr", 32'(bus.imem_addr), 32'd2);

    // jal with valid held: fills last slot, further requests refused
    set_req(1'b1, 26, 3, 3, 3, 3, 3, 26'h10);
    tick();
    tick();
    check_val("jal_word", bus.imem_wdata, 32'h0C000010);
    check_val("jal_addr", 32'(bus.imem_addr), 32'd3);
    tick();
    check_val("full_flag", 32'(bus.full), 32'd1);
    check_val("full_ready", 32'(bus.in_ready), 32'd0);
    repeat (4) tick();

    // clear out of FULL, next write at BASE
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("clr_full", 32'(bus.full), 32'd0);
    set_req(1'b1, 23, 4, 5, 0, 0, 16'hbeef, 0);
    tick();
    check_val("clr_addr", 32'(bus.imem_addr), 32'd0);

    // clear during WRITE aborts the write
    set_req(1'b0, 0, 0, 0, 0, 0, 0, 0);
    clear = 1'b1;
    #1;
    check_val("abort_we", 32'(bus.imem_we), 32'd0);
    tick();
    clear = 1'b0;
    check_val("abort_count", 32'(bus.count), 32'd0);

    // request presented with clear is not accepted
    set_req(1'b1, 0, 1, 1, 1, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    set_req(1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check_val("clr_req_we", 32'(bus.imem_we), 32'd0);

    // async reset in the middle of a WRITE
    set_req(1'b1, 16, 2, 3, 0, 0, 16'h0010, 0);
    tick();
    set_req(1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_req(1'b1, 19, 6, 7, 0, 0, 16'h0008, 0);
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_val("rst_count", 32'(bus.count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(1'b1, 25, 0, 0, 0, 0, 0, 26'h123456);
    tick();
    check_val("rst_resume_addr", 32'(bus.imem_addr), 32'(BASE));
    check_val("rst_resume_word", bus.imem_wdata, 32'h08123456);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int unsigned op;
      op = ($urandom_range(0, 7) == 0) ? $urandom_range(27, 31) : $urandom_range(0, 26);
      set_req($urandom_range(0, 3) != 0, op, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom);
      clear = ($urandom_range(0, 19) == 0);
      tick();
    end
    clear = 1'b0;
    set_req(1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
